// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
//   one bit per clock through a full-subtractor cell and a borrow flip-flop.
//   A start pulse accepted in IDLE loads the operands. WIDTH edges later,
//   diff/bout are updated and done pulses high for one cycle.
//
//   Handshake: start is a request that is honoured only when busy=0, which is
//   the IDLE state. The operands a/b are captured on that accepting edge only.
//   A start seen while busy=1 is dropped, not queued. done is a one-cycle
//   qualifier meaning "diff/bout were just written". Between done pulses,
//   diff/bout hold the last completed result.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset (aborts any operation)
//   start  in   1      load a/b and begin (IDLE only)
//   a      in   WIDTH  minuend
//   b      in   WIDTH  subtrahend
//   busy   out  1      registered, high while state != IDLE
//   done   out  1      registered one-cycle result strobe
//   diff   out  WIDTH  registered difference
//   bout   out  1      registered final borrow (1 when a < b, unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Last bit index. With CW = clog2(WIDTH), this still fits when WIDTH is a
    // power of two, so count never has to reach WIDTH itself.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic [CW-1:0]    count;

    // Full-subtractor cell on the current LSBs.
    logic d;
    logic br_next;
    logic last_bit;

    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        last_bit = (count == LAST);
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: if (last_bit) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            // busy follows the state being entered so it is aligned with it.
            busy <= (next_state != S_IDLE);
            done <= (state == S_SHIFT) && last_bit;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        r_sr  <= '0;
                        br    <= 1'b0;
                        count <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= {d, r_sr[WIDTH-1:1]};
                    br    <= br_next;
                    // Wraps to zero after the last bit when WIDTH is a power
                    // of two. That is harmless because IDLE reloads count.
                    count <= count + 1'b1;
                    if (last_bit) begin
                        diff <= {d, r_sr[WIDTH-1:1]};
                        bout <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
